// File: rtl/mem_stage.sv
// RV32I memory-access stage: drives the data bus, formats load data, builds store
// byte-enables, and owns the MEM/WB register. Upstream is stalled while an access is pending.
module mem_stage #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_mem_valid,
  input  logic [31:0] ex_mem_pc_4,
  input  logic [31:0] ex_mem_alu_result,
  input  logic [31:0] ex_mem_rs2_data,
  input  logic [4:0]  ex_mem_rd,
  input  logic        ex_mem_reg_write_en,
  input  logic [1:0]  ex_mem_mem_to_reg_sel,
  input  logic        ex_mem_mem_read,
  input  logic        ex_mem_mem_write,
  input  logic [2:0]  ex_mem_funct3,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic        stall_out,
  output logic        misaligned,
  output logic        bus_err,
  output logic [31:0] mem_wb_pc_4,
  output logic [31:0] mem_wb_alu_result,
  output logic [31:0] mem_wb_mem_read_data,
  output logic [4:0]  mem_wb_rd,
  output logic        mem_wb_reg_write_en,
  output logic [1:0]  mem_wb_mem_to_reg_sel
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          misaligned_q, misaligned_d;
  logic          bus_err_q, bus_err_d;
  logic [31:0]   wb_pc_4_q, wb_pc_4_d;
  logic [31:0]   wb_alu_q, wb_alu_d;
  logic [31:0]   wb_data_q, wb_data_d;
  logic [4:0]    wb_rd_q, wb_rd_d;
  logic          wb_we_q, wb_we_d;
  logic [1:0]    wb_sel_q, wb_sel_d;

  logic        aligned, mem_acc, mem_op, req_raw, done, abort, stall_raw;
  logic [1:0]  lane;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  assign lane = ex_mem_alu_result[1:0];

  always_comb begin
    unique case (ex_mem_funct3[1:0])
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~lane[0];
      default: aligned = (lane == 2'b00);
    endcase
  end

  always_comb begin
    mem_acc   = ex_mem_valid & (ex_mem_mem_read | ex_mem_mem_write);
    mem_op    = mem_acc & aligned;
    req_raw   = (state_q == S_WAIT) | mem_op;
    done      = req_raw & dmem_ready;
    abort     = (state_q == S_WAIT) & ~dmem_ready & (cnt_q == CNT_LAST);
    stall_raw = req_raw & ~done & ~abort;
  end

  // Reset gates the combinational handshake so a reset mid-access drops it at once.
  assign dmem_req  = rst & req_raw;
  assign stall_out = rst & stall_raw;
  assign dmem_we   = ex_mem_mem_write & ~ex_mem_mem_read;
  assign dmem_addr = {ex_mem_alu_result[31:2], 2'b00};

  always_comb begin
    dmem_be    = 4'b1111;
    dmem_wdata = ex_mem_rs2_data;
    if (dmem_we) begin
      unique case (ex_mem_funct3[1:0])
        2'b00: begin
          dmem_be    = 4'b0001 << lane;
          dmem_wdata = {4{ex_mem_rs2_data[7:0]}};
        end
        2'b01: begin
          dmem_be    = lane[1] ? 4'b1100 : 4'b0011;
          dmem_wdata = {2{ex_mem_rs2_data[15:0]}};
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ld_byte = dmem_rdata[{lane, 3'b000} +: 8];
    ld_half = lane[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    unique case (ex_mem_funct3)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = dmem_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: if (mem_op && !dmem_ready) begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        if (dmem_ready || abort) state_d = S_IDLE;
        else                     cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Anything that does not retire cleanly this cycle becomes a bubble.
  always_comb begin
    misaligned_d = mem_acc & ~aligned;
    bus_err_d    = abort;
    wb_pc_4_d    = '0;
    wb_alu_d     = '0;
    wb_data_d    = '0;
    wb_rd_d      = '0;
    wb_we_d      = 1'b0;
    wb_sel_d     = 2'b00;
    if (ex_mem_valid && !stall_raw && !abort && !misaligned_d) begin
      wb_pc_4_d = ex_mem_pc_4;
      wb_alu_d  = ex_mem_alu_result;
      wb_data_d = ex_mem_mem_read ? ld_data : 32'd0;
      wb_rd_d   = ex_mem_rd;
      wb_we_d   = ex_mem_reg_write_en;
      wb_sel_d  = ex_mem_mem_to_reg_sel;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      misaligned_q <= 1'b0;
      bus_err_q    <= 1'b0;
      wb_pc_4_q    <= '0;
      wb_alu_q     <= '0;
      wb_data_q    <= '0;
      wb_rd_q      <= '0;
      wb_we_q      <= 1'b0;
      wb_sel_q     <= 2'b00;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      misaligned_q <= misaligned_d;
      bus_err_q    <= bus_err_d;
      wb_pc_4_q    <= wb_pc_4_d;
      wb_alu_q     <= wb_alu_d;
      wb_data_q    <= wb_data_d;
      wb_rd_q      <= wb_rd_d;
      wb_we_q      <= wb_we_d;
      wb_sel_q     <= wb_sel_d;
    end
  end

  assign misaligned            = misaligned_q;
  assign bus_err               = bus_err_q;
  assign mem_wb_pc_4           = wb_pc_4_q;
  assign mem_wb_alu_result     = wb_alu_q;
  assign mem_wb_mem_read_data  = wb_data_q;
  assign mem_wb_rd             = wb_rd_q;
  assign mem_wb_reg_write_en   = wb_we_q;
  assign mem_wb_mem_to_reg_sel = wb_sel_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: stimulus pushes expected MEM/WB events into a queue,
// a negedge monitor pops and compares whenever a writeback, misaligned or bus_err appears.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_mem_valid;
  logic [31:0] ex_mem_pc_4, ex_mem_alu_result, ex_mem_rs2_data;
  logic [4:0]  ex_mem_rd;
  logic        ex_mem_reg_write_en;
  logic [1:0]  ex_mem_mem_to_reg_sel;
  logic        ex_mem_mem_read, ex_mem_mem_write;
  logic [2:0]  ex_mem_funct3;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready;
  logic        stall_out, misaligned, bus_err;
  logic [31:0] mem_wb_pc_4, mem_wb_alu_result, mem_wb_mem_read_data;
  logic [4:0]  mem_wb_rd;
  logic        mem_wb_reg_write_en;
  logic [1:0]  mem_wb_mem_to_reg_sel;

  mem_stage #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .ex_mem_valid(ex_mem_valid), .ex_mem_pc_4(ex_mem_pc_4),
    .ex_mem_alu_result(ex_mem_alu_result), .ex_mem_rs2_data(ex_mem_rs2_data),
    .ex_mem_rd(ex_mem_rd), .ex_mem_reg_write_en(ex_mem_reg_write_en),
    .ex_mem_mem_to_reg_sel(ex_mem_mem_to_reg_sel), .ex_mem_mem_read(ex_mem_mem_read),
    .ex_mem_mem_write(ex_mem_mem_write), .ex_mem_funct3(ex_mem_funct3),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_rdata(dmem_rdata),
    .dmem_ready(dmem_ready), .stall_out(stall_out), .misaligned(misaligned),
    .bus_err(bus_err), .mem_wb_pc_4(mem_wb_pc_4), .mem_wb_alu_result(mem_wb_alu_result),
    .mem_wb_mem_read_data(mem_wb_mem_read_data), .mem_wb_rd(mem_wb_rd),
    .mem_wb_reg_write_en(mem_wb_reg_write_en), .mem_wb_mem_to_reg_sel(mem_wb_mem_to_reg_sel)
  );

  always #5 clk = ~clk;

  localparam int K_WB = 0, K_MIS = 1, K_BERR = 2;
  typedef struct {
    int          kind;
    logic [4:0]  rd;
    logic [31:0] data, alu, pc4;
    logic [1:0]  sel;
  } exp_t;

  exp_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input int kind, input logic [4:0] rd, input logic [31:0] data,
                      input logic [31:0] alu, input logic [31:0] pc4, input logic [1:0] sel);
    exp_t e;
    e.kind = kind; e.rd = rd; e.data = data; e.alu = alu; e.pc4 = pc4; e.sel = sel;
    sb.push_back(e);
  endtask

  task automatic idle_in();
    ex_mem_valid = 0; ex_mem_pc_4 = 0; ex_mem_alu_result = 0; ex_mem_rs2_data = 0;
    ex_mem_rd = 0; ex_mem_reg_write_en = 0; ex_mem_mem_to_reg_sel = 0;
    ex_mem_mem_read = 0; ex_mem_mem_write = 0; ex_mem_funct3 = 0;
    dmem_ready = 0; dmem_rdata = 0;
  endtask

  task automatic op(input logic [2:0] f3, input logic [4:0] rd, input logic rwe,
                    input logic [1:0] sel, input logic mr, input logic mw,
                    input logic [31:0] alu, input logic [31:0] rs2, input logic [31:0] pc4);
    ex_mem_valid = 1; ex_mem_funct3 = f3; ex_mem_rd = rd; ex_mem_reg_write_en = rwe;
    ex_mem_mem_to_reg_sel = sel; ex_mem_mem_read = mr; ex_mem_mem_write = mw;
    ex_mem_alu_result = alu; ex_mem_rs2_data = rs2; ex_mem_pc_4 = pc4;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  // Monitor: any retiring writeback or status pulse must match the queue head.
  always @(negedge clk) begin
    if (rst && (mem_wb_reg_write_en || misaligned || bus_err)) begin
      if (sb.size() == 0) begin
        chk("unexpected_event", {29'd0, bus_err, misaligned, mem_wb_reg_write_en}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("ev_misaligned", {31'd0, misaligned}, {31'd0, e.kind == K_MIS});
        chk("ev_bus_err",    {31'd0, bus_err},    {31'd0, e.kind == K_BERR});
        chk("ev_reg_we",     {31'd0, mem_wb_reg_write_en}, {31'd0, e.kind == K_WB});
        chk("ev_sel",        {30'd0, mem_wb_mem_to_reg_sel}, {30'd0, e.sel});
        if (e.kind == K_WB) begin
          chk("wb_rd",   {27'd0, mem_wb_rd}, {27'd0, e.rd});
          chk("wb_data", mem_wb_mem_read_data, e.data);
          chk("wb_alu",  mem_wb_alu_result, e.alu);
          chk("wb_pc4",  mem_wb_pc_4, e.pc4);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int stalls;
    int guard;
    rst = 0;
    idle_in();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wb_we",   {31'd0, mem_wb_reg_write_en}, 32'd0);
    chk("rst_wb_data", mem_wb_mem_read_data, 32'd0);
    chk("rst_wb_pc4",  mem_wb_pc_4, 32'd0);
    chk("rst_req",     {31'd0, dmem_req}, 32'd0);
    chk("rst_pulses",  {30'd0, misaligned, bus_err}, 32'd0);
    @(negedge clk) rst = 1;
    next_cycle();

    // LW zero-wait
    op(3'b010, 5'd5, 1, 2'b01, 1, 0, 32'h100, 32'h0, 32'h1004);
    dmem_ready = 1; dmem_rdata = 32'hDEADBEEF;
    #1;
    chk("lw_req",   {31'd0, dmem_req}, 32'd1);
    chk("lw_stall", {31'd0, stall_out}, 32'd0);
    chk("lw_addr",  dmem_addr, 32'h100);
    chk("lw_be",    {28'd0, dmem_be}, 32'hF);
    push(K_WB, 5'd5, 32'hDEADBEEF, 32'h100, 32'h1004, 2'b01);
    next_cycle();

    // LB / LBU lane 3, LH / LHU
    op(3'b000, 5'd6, 1, 2'b01, 1, 0, 32'h103, 32'h0, 32'h1008);
    dmem_ready = 1; dmem_rdata = 32'h80123456;
    #1 chk("lb_addr", dmem_addr, 32'h100);
    push(K_WB, 5'd6, 32'hFFFFFF80, 32'h103, 32'h1008, 2'b01);
    next_cycle();
    op(3'b100, 5'd7, 1, 2'b01, 1, 0, 32'h103, 32'h0, 32'h100C);
    push(K_WB, 5'd7, 32'h00000080, 32'h103, 32'h100C, 2'b01);
    next_cycle();
    op(3'b001, 5'd8, 1, 2'b01, 1, 0, 32'h102, 32'h0, 32'h1010);
    dmem_rdata = 32'h80011234;
    push(K_WB, 5'd8, 32'hFFFF8001, 32'h102, 32'h1010, 2'b01);
    next_cycle();
    op(3'b101, 5'd9, 1, 2'b01, 1, 0, 32'h100, 32'h0, 32'h1014);
    push(K_WB, 5'd9, 32'h00001234, 32'h100, 32'h1014, 2'b01);
    next_cycle();

    // Stores
    op(3'b001, 5'd0, 0, 2'b00, 0, 1, 32'h102, 32'h1234ABCD, 32'h1018);
    #1;
    chk("sh_be",    {28'd0, dmem_be}, 32'hC);
    chk("sh_wdata", dmem_wdata, 32'hABCDABCD);
    chk("sh_we",    {31'd0, dmem_we}, 32'd1);
    chk("sh_req",   {31'd0, dmem_req}, 32'd1);
    next_cycle();
    op(3'b000, 5'd0, 0, 2'b00, 0, 1, 32'h101, 32'h000000EF, 32'h101C);
    #1;
    chk("sb_be",    {28'd0, dmem_be}, 32'h2);
    chk("sb_wdata", dmem_wdata, 32'hEFEFEFEF);
    next_cycle();
    op(3'b010, 5'd0, 0, 2'b00, 0, 1, 32'h200, 32'hCAFEF00D, 32'h1020);
    #1;
    chk("sw_be",    {28'd0, dmem_be}, 32'hF);
    chk("sw_wdata", dmem_wdata, 32'hCAFEF00D);
    next_cycle();

    // Non-memory pass-through: ALU and PC+4
    dmem_ready = 0;
    op(3'b000, 5'd3, 1, 2'b00, 0, 0, 32'h55, 32'h0, 32'h2004);
    #1;
    chk("alu_req",   {31'd0, dmem_req}, 32'd0);
    chk("alu_stall", {31'd0, stall_out}, 32'd0);
    push(K_WB, 5'd3, 32'h0, 32'h55, 32'h2004, 2'b00);
    next_cycle();
    op(3'b000, 5'd1, 1, 2'b10, 0, 0, 32'h0, 32'h0, 32'h2008);
    push(K_WB, 5'd1, 32'h0, 32'h0, 32'h2008, 2'b10);
    next_cycle();
    idle_in();
    next_cycle();

    // LW with ready on the 4th cycle: 3 stalls, 3 bubbles
    op(3'b010, 5'd10, 1, 2'b01, 1, 0, 32'h300, 32'h0, 32'h3004);
    stalls = 0;
    for (int i = 0; i < 3; i++) begin
      #1 if (stall_out) stalls++;
      next_cycle();
      chk("wait_bubble", {31'd0, mem_wb_reg_write_en}, 32'd0);
    end
    dmem_ready = 1; dmem_rdata = 32'h0BADF00D;
    #1 chk("wait_done_stall", {31'd0, stall_out}, 32'd0);
    chk("wait_stalls", stalls, 3);
    push(K_WB, 5'd10, 32'h0BADF00D, 32'h300, 32'h3004, 2'b01);
    next_cycle();
    idle_in();
    next_cycle();

    // Timeout: 1 IDLE + 15 WAIT stall cycles, abort on the 16th WAIT cycle
    op(3'b010, 5'd11, 1, 2'b01, 1, 0, 32'h400, 32'h0, 32'h4004);
    stalls = 0;
    guard  = 0;
    while (guard < 40) begin
      #1;
      if (!stall_out) break;
      stalls++;
      guard++;
      next_cycle();
    end
    chk("to_guard",  {31'd0, guard < 40}, 32'd1);
    chk("to_stalls", stalls, 16);
    chk("to_req",    {31'd0, dmem_req}, 32'd1);
    push(K_BERR, 5'd0, 32'h0, 32'h0, 32'h0, 2'b00);
    next_cycle();
    idle_in();
    next_cycle();
    #1 chk("to_idle_req", {31'd0, dmem_req}, 32'd0);
    next_cycle();

    // Misaligned LH
    op(3'b001, 5'd12, 1, 2'b01, 1, 0, 32'h101, 32'h0, 32'h5004);
    #1;
    chk("mis_req",   {31'd0, dmem_req}, 32'd0);
    chk("mis_stall", {31'd0, stall_out}, 32'd0);
    push(K_MIS, 5'd0, 32'h0, 32'h0, 32'h0, 2'b00);
    next_cycle();
    idle_in();
    next_cycle();

    // Reset mid-WAIT
    op(3'b010, 5'd13, 1, 2'b01, 1, 0, 32'h500, 32'h0, 32'h6004);
    next_cycle();
    next_cycle();
    #1 chk("pre_rst_stall", {31'd0, stall_out}, 32'd1);
    rst = 0;
    #1;
    chk("arst_req",   {31'd0, dmem_req}, 32'd0);
    chk("arst_stall", {31'd0, stall_out}, 32'd0);
    chk("arst_wb",    {26'd0, mem_wb_reg_write_en, mem_wb_rd}, 32'd0);
    chk("arst_pulse", {30'd0, misaligned, bus_err}, 32'd0);
    idle_in();
    next_cycle();
    @(negedge clk) rst = 1;
    repeat (3) next_cycle();
    chk("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
